// File: rtl/sn76489_cmd_writer_if.sv
// Command and PSG bus bundle for sn76489_cmd_writer.
// The slave modport is the writer itself; master is the surrounding system
// (sound-register decoder on the command side, PSG model on the bus side).
interface sn76489_cmd_writer_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_chan_i;
  logic       cmd_vol_i;
  logic [9:0] cmd_data_i;
  logic       psg_ce_n_o;
  logic       psg_we_n_o;
  logic [0:7] psg_d_o;
  logic       psg_ready_i;
  logic       busy_o;
  logic       err_o;

  modport slave (
    input  cmd_valid_i, cmd_chan_i, cmd_vol_i, cmd_data_i, psg_ready_i,
    output cmd_ready_o, psg_ce_n_o, psg_we_n_o, psg_d_o, busy_o, err_o
  );

  modport master (
    output cmd_valid_i, cmd_chan_i, cmd_vol_i, cmd_data_i, psg_ready_i,
    input  cmd_ready_o, psg_ce_n_o, psg_we_n_o, psg_d_o, busy_o, err_o
  );
endinterface

// File: rtl/sn76489_cmd_writer.sv
// Host-side command encoder and bus sequencer for the SN76489 PSG.
// Channel-level commands are queued, encoded into latch/data bytes and
// written to the PSG one complete ce_n/we_n cycle per byte, waiting on
// psg_ready_i with a timeout that abandons a stuck byte and flags err_o.
module sn76489_cmd_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int STROBE_MIN = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                   clock_i,
  input  logic                   res_i,
  sn76489_cmd_writer_if.slave    bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   DEPTH_C      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] STROBE_MIN_C = CW'(STROBE_MIN);
  localparam logic [CW-1:0] TIMEOUT_C    = CW'(TIMEOUT);

  typedef struct packed {
    logic [1:0] chan;
    logic       vol;
    logic [9:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE
  } state_t;

  // FIFO
  cmd_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;
  cmd_t          head;

  // Sequencer
  state_t        state;
  state_t        state_next;
  logic          load_a;
  logic          load_b;
  logic          timeout_hit;
  logic          strobe_n;
  logic [CW-1:0] cnt;
  logic          b_pending;
  logic [0:7]    b_byte;
  logic [0:7]    psg_d;
  logic [0:7]    byte_a;
  logic [3:0]    field;
  logic          busy;
  logic          err;

  // Readiness depends only on the registered count, so a pop in the same
  // cycle never makes room for a push.
  assign bus.cmd_ready_o = (count < DEPTH_C);
  assign push            = bus.cmd_valid_i && bus.cmd_ready_o;
  assign head            = mem[rd_ptr];

  // Command storage: written on accepted pushes only.
  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are valid, and resetting RAM would cost flops for nothing.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr] <= '{chan: bus.cmd_chan_i, vol: bus.cmd_vol_i, data: bus.cmd_data_i};
    end
  end

  // Occupancy after this cycle's push/pop; a simultaneous pair cancels.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Latch byte encoding of the FIFO head: noise control uses 3 data bits,
  // every other register takes the low nibble.
  always_comb begin
    field = head.data[3:0];
    if (!head.vol && head.chan == 2'd3) begin
      field = {1'b0, head.data[2:0]};
    end
    byte_a = {1'b1, head.chan, head.vol, field};
  end

  // FSM state register.
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and per-state controls.
  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    timeout_hit = 1'b0;
    strobe_n    = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          load_a     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = STROBE;
      end
      STROBE: begin
        strobe_n = 1'b0;
        if (cnt >= STROBE_MIN_C && bus.psg_ready_i) begin
          state_next = RELEASE;
        end else if (cnt == TIMEOUT_C) begin
          timeout_hit = 1'b1;
          state_next  = RELEASE;
        end
      end
      RELEASE: begin
        if (b_pending) begin
          load_b     = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Data byte, pending second byte, strobe counter and status flags.
  always_ff @(posedge clock_i) begin
    if (res_i) begin
      psg_d     <= '0;
      b_byte    <= '0;
      b_pending <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (load_a) begin
        psg_d     <= byte_a;
        b_byte    <= {2'b00, head.data[9:4]};
        b_pending <= !head.vol && (head.chan != 2'd3);
      end else if (load_b) begin
        psg_d     <= b_byte;
        b_pending <= 1'b0;
      end
      // Counter reads 1 in the first STROBE cycle; it never passes TIMEOUT.
      if (state == SETUP) begin
        cnt <= CW'(1);
      end else if (state == STROBE) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
      busy <= (state_next != IDLE) || (count_next != '0);
    end
  end

  assign bus.psg_ce_n_o = strobe_n;
  assign bus.psg_we_n_o = strobe_n;
  assign bus.psg_d_o    = psg_d;
  assign bus.busy_o     = busy;
  assign bus.err_o      = err;

endmodule

// File: tb/tb_sn76489_cmd_writer.sv
// Scoreboard bench for sn76489_cmd_writer: stimulus pushes the expected PSG
// byte writes into a queue, a monitor pops one per completed strobe and
// compares data, strobe length, data stability and we_n/ce_n agreement.
module tb_sn76489_cmd_writer;

  typedef struct {
    logic [7:0] data;
    int         len;   // 0 = strobe length not checked
  } wr_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  wr_t  exp_q[$];

  sn76489_cmd_writer_if bus ();

  sn76489_cmd_writer #(
    .FIFO_DEPTH(4),
    .STROBE_MIN(2),
    .TIMEOUT   (255)
  ) dut (
    .clock_i(clk),
    .res_i  (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [7:0] d, input int len);
    wr_t e;
    e.data = d;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Offer one command for one cycle; called 1ns after a rising edge.
  task automatic offer(input logic [1:0] ch, input logic v, input logic [9:0] dat,
                       output logic acc);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_chan_i  = ch;
    bus.cmd_vol_i   = v;
    bus.cmd_data_i  = dat;
    acc = bus.cmd_ready_o;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy_o !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.busy_o, 1'b0);
  endtask

  // Monitor: one scoreboard comparison per completed byte write.
  initial begin
    logic       in_wr  = 1'b0;
    logic       stable = 1'b1;
    logic       we_ok  = 1'b1;
    logic [7:0] cap    = '0;
    int         len    = 0;
    wr_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_wr = 1'b0;
      end else if (bus.psg_ce_n_o === 1'b0) begin
        if (!in_wr) begin
          in_wr  = 1'b1;
          len    = 1;
          cap    = bus.psg_d_o;
          stable = 1'b1;
          we_ok  = 1'b1;
        end else begin
          len++;
          if (bus.psg_d_o !== cap) stable = 1'b0;
        end
        if (bus.psg_we_n_o !== 1'b0) we_ok = 1'b0;
      end else if (in_wr) begin
        in_wr = 1'b0;
        check("wr_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_data", cap, e.data);
          if (e.len != 0) check("wr_strobe_len", len, e.len);
          check("wr_data_stable", stable, 1'b1);
          check("wr_we_n", we_ok, 1'b1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [7:0] d_before;
    int         n;

    rst             = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_chan_i  = '0;
    bus.cmd_vol_i   = 1'b0;
    bus.cmd_data_i  = '0;
    bus.psg_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ce_n", bus.psg_ce_n_o, 1'b1);
    check("rst_we_n", bus.psg_we_n_o, 1'b1);
    check("rst_d", bus.psg_d_o, 8'h00);
    check("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);
    @(posedge clk);
    #1;

    // Tone 1 frequency 0x1AB: bytes 0x8B then 0x1A.
    offer(2'd0, 1'b0, 10'h1AB, acc);
    check("t1_accept", acc, 1'b1);
    expect_wr(8'h8B, 2);
    expect_wr(8'h1A, 2);
    @(negedge clk);                       // IDLE, between N and N+1
    @(negedge clk);                       // SETUP
    check("t1_setup_ce_n", bus.psg_ce_n_o, 1'b1);
    check("t1_setup_d", bus.psg_d_o, 8'h8B);
    @(negedge clk);                       // first STROBE cycle, N+2
    check("t1_strobe_low", bus.psg_ce_n_o, 1'b0);
    repeat (6) @(negedge clk);            // second RELEASE
    check("t1_busy_release", bus.busy_o, 1'b1);
    @(negedge clk);                       // back in IDLE
    check("t1_busy_drop", bus.busy_o, 1'b0);
    @(posedge clk);
    #1;

    // Tone 3 attenuation and noise control, back to back.
    offer(2'd2, 1'b1, 10'h00F, acc);
    check("t2_accept_att", acc, 1'b1);
    expect_wr(8'hDF, 2);
    offer(2'd3, 1'b0, 10'h3FD, acc);
    check("t2_accept_noise", acc, 1'b1);
    expect_wr(8'hE5, 2);
    wait_idle("t2_idle", 100);
    @(posedge clk);
    #1;

    // PSG stall: ready low for the first 20 STROBE cycles.
    bus.psg_ready_i = 1'b0;
    offer(2'd1, 1'b1, 10'h007, acc);
    check("t3_accept", acc, 1'b1);
    expect_wr(8'hB7, 21);
    repeat (22) @(posedge clk);
    #1;
    bus.psg_ready_i = 1'b1;
    wait_idle("t3_idle", 100);
    check("t3_err_clear", bus.err_o, 1'b0);
    @(posedge clk);
    #1;

    // Timeout on both bytes of a two-byte command.
    bus.psg_ready_i = 1'b0;
    offer(2'd1, 1'b0, 10'h2C5, acc);
    check("t4_accept", acc, 1'b1);
    expect_wr(8'hA5, 255);
    expect_wr(8'h2C, 255);
    repeat (200) @(negedge clk);
    check("t4_err_before", bus.err_o, 1'b0);
    wait_idle("t4_idle", 1000);
    check("t4_err_set", bus.err_o, 1'b1);
    bus.psg_ready_i = 1'b1;
    @(posedge clk);
    #1;

    // FIFO fill with the PSG stalled, excess push, push during pop while full.
    bus.psg_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      offer(2'd0, 1'b1, 10'(i), acc);
      check("t5_accept", acc, 1'b1);
      expect_wr(8'h90 | 8'(i), (i == 1) ? 0 : 2);
    end
    check("t5_full_ready", bus.cmd_ready_o, 1'b0);
    offer(2'd0, 1'b1, 10'h006, acc);
    check("t5_excess_refused", acc, 1'b0);
    bus.psg_ready_i = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      d_before = bus.psg_d_o;
      offer(2'd0, 1'b1, 10'h007, acc);
      n++;
    end
    check("t5_late_accept", acc, 1'b1);
    check("t5_pop_before_push", d_before, 8'h92);
    expect_wr(8'h97, 2);
    wait_idle("t5_idle", 200);
    check("t5_err_sticky", bus.err_o, 1'b1);
    @(posedge clk);
    #1;

    // Reset in the middle of byte A with three commands queued.
    bus.psg_ready_i = 1'b0;
    offer(2'd0, 1'b0, 10'h123, acc);
    check("t6_accept", acc, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      offer(2'(i), 1'b1, 10'(i), acc);
      check("t6_accept_q", acc, 1'b1);
    end
    repeat (2) @(negedge clk);
    check("t6_in_strobe", bus.psg_ce_n_o, 1'b0);
    check("t6_err_before_rst", bus.err_o, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_ce_n", bus.psg_ce_n_o, 1'b1);
    check("t6_we_n", bus.psg_we_n_o, 1'b1);
    check("t6_busy", bus.busy_o, 1'b0);
    check("t6_ready", bus.cmd_ready_o, 1'b1);
    check("t6_err_clear", bus.err_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.psg_ready_i = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_busy_after", bus.busy_o, 1'b0);
    check("t6_ce_n_after", bus.psg_ce_n_o, 1'b1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sn76489_cmd_writer.md
# sn76489_cmd_writer

Host-side command encoder and bus sequencer for the SN76489 PSG core. It accepts channel-level register commands (channel, register type, value), queues them in a small FIFO, and encodes each one into the PSG latch/data byte format. It then drives the PSG CPU interface (chip-enable, write-enable, data bus) with a complete write cycle per byte, honouring the PSG ready handshake. It sits between the system sound-register decoder and the PSG top level, so upstream logic never issues raw PSG bytes or waits on ready.

## Interface
- FIFO_DEPTH, 4, number of queued commands; power of two, ≥2.
- STROBE_MIN, 2, minimum cycles ce_n/we_n are held low per byte; ≥1.
- TIMEOUT, 255, maximum STROBE cycles spent waiting for ready before the byte is abandoned; must be > STROBE_MIN.
- clock_i  in  1  system clock; single clock domain.
- res_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command offered this cycle.
- cmd_ready_o  out  1  FIFO not full; a command is accepted on the edge where cmd_valid_i && cmd_ready_o.
- cmd_chan_i  in  2  0/1/2 = tone 1/2/3, 3 = noise.
- cmd_vol_i  in  1  1 = attenuation register, 0 = tone-frequency/noise-control register.
- cmd_data_i  in  10  value; width used depends on the register.
- psg_ce_n_o  out  1  PSG chip enable, active low.
- psg_we_n_o  out  1  PSG write enable, active low.
- psg_d_o  out  [0:7]  PSG data; bit 0 is the MSB (latch flag).
- psg_ready_i  in  1  PSG ready; low while the PSG is absorbing a write.
- busy_o  out  1  FSM not IDLE or FIFO non-empty.
- err_o  out  1  sticky; set when any byte times out.

## Operation
- FIFO: FIFO_DEPTH × 13 bits {chan, vol, data}. cmd_ready_o = (count < FIFO_DEPTH), based on the registered count only.
  - No pass-through: a push and a pop in the same cycle are both legal, and the count is unchanged.
  - A push while full is ignored.
- Encoding (bit 0 = MSB):
  - Byte A is always 1, chan[1], chan[0], vol, then a 4-bit field F.
  - vol=1: F = data[3:0]. One byte only.
  - vol=0, chan=3: F = {0, data[2:0]}. One byte only.
  - vol=0, chan<3: F = data[3:0], followed by byte B = {0, 0, data[9:4]}. Two bytes.
  - Unused data bits are ignored.
- FSM states:
  - IDLE: ce_n/we_n high. If the FIFO is non-empty, pop the head, latch the entry, load byte A, and go to SETUP.
  - SETUP (1 cycle): psg_d_o is valid, strobes high. Go to STROBE.
  - STROBE: ce_n = we_n = 0. A cycle counter starts at 1. Leave for RELEASE on the first cycle where counter ≥ STROBE_MIN and psg_ready_i=1. If counter = TIMEOUT without that, set err_o and go to RELEASE; the byte counts as done.
  - RELEASE (1 cycle): strobes high, psg_d_o held. If byte B is pending, load it and go to SETUP. Otherwise go to IDLE.
- psg_d_o is held stable from SETUP through RELEASE. It keeps its last value in IDLE.
- A timeout on byte A of a two-byte command does not skip byte B.

## Timing
- Reset values: psg_ce_n_o=1, psg_we_n_o=1, psg_d_o=0x00, cmd_ready_o=1, busy_o=0, err_o=0. FIFO is empty and the FSM is in IDLE.
- res_i mid-operation: strobes go high at that edge. The in-flight command, its pending byte B, and all queued commands are discarded.
- Command accepted at edge N, FIFO previously empty and FSM in IDLE:
  - pop and SETUP at N+1 (psg_d_o valid);
  - strobes low from N+2;
  - with psg_ready_i held high and STROBE_MIN=2, RELEASE at N+4.
- Single byte: SETUP + STROBE_MIN + RELEASE = 4 cycles minimum.
- Two-byte command: 8 cycles minimum. Back-to-back commands have one IDLE cycle between them.
- psg_ready_i is sampled only in STROBE. A low-then-high ready pulse inside the first STROBE_MIN cycles still requires ready=1 at the exit cycle.
- busy_o is registered and deasserts the cycle the FSM returns to IDLE with the FIFO empty.

## Test plan
- Tone 1 frequency 0x1AB (chan=0, vol=0), psg_ready_i=1 -> byte 0x8B with 2 strobe cycles, one release cycle, then byte 0x1A. Strobes first go low 2 cycles after acceptance. busy_o drops after the second RELEASE.
- Tone 3 attenuation 0xF (chan=2, vol=1) -> single byte 0xDF. Noise control 0x5 (chan=3, vol=0, data=0x3FD) -> single byte 0xE5, with upper data bits ignored.
- PSG stall: psg_ready_i low for 20 cycles starting at STROBE entry -> strobes stay low exactly 21 cycles, psg_d_o stays stable, err_o stays 0.
- Timeout: psg_ready_i stuck low on a two-byte command -> err_o sets after 255 STROBE cycles, byte B is still issued, err_o stays set until res_i.
- FIFO full/simultaneous: push 5 commands back-to-back with ready held low -> cmd_ready_o deasserts once the FIFO is full, and the excess push is ignored. A push on the cycle of a pop while full is refused. All accepted commands emerge in order.
- Reset mid-STROBE of byte A with 3 commands queued -> strobes high the next cycle, no byte B, FIFO empty, busy_o=0, cmd_ready_o=1.
